// File: rtl/dmem_pkg.sv
// Shared types and access-check helpers for the data-memory load/store unit.
package dmem_pkg;

    // RV32 load/store funct3 encodings
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } func3_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Access size in bytes; 0 for an encoding that is not a load/store width
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        logic [2:0] size;
        case (f3)
            F3_B, F3_BU: size = 3'd1;
            F3_H, F3_HU: size = 3'd2;
            F3_W:        size = 3'd4;
            default:     size = 3'd0;
        endcase
        return size;
    endfunction

    // True when funct3 is legal for the direction and the offset is naturally aligned
    function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic f3_ok;
        logic aligned;
        if (we)
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        case (access_size(f3))
            3'd2:    aligned = !off[0];
            3'd4:    aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
        return f3_ok && aligned;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the pipeline and the load/store unit.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_byte_array.sv
// Word-organised data memory with per-byte write enables and asynchronous read.
module dmem_byte_array #(
    parameter int unsigned DEPTH_BYTES = 1024,
    localparam int unsigned WORDS = DEPTH_BYTES / 4,
    localparam int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Byte-lane writes; contents are intentionally not reset
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i])
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_lsu.sv
// Memory-stage load/store unit: captures one request, waits WAIT_CYCLES, accesses
// the embedded byte array, and holds the (extended) result until consumed.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus
);

    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned AW = $clog2(DEPTH_BYTES / 4);

    state_e        state;
    state_e        state_next;
    logic [CW-1:0] cnt;

    logic          cap_we;
    logic [2:0]    cap_f3;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;

    logic [31:0]   rdata_q;
    logic          err_q;

    logic          req_ready;
    logic          rsp_valid;
    logic          accept;
    logic          commit;

    logic [1:0]    off;
    logic [2:0]    size;
    logic          acc_err;
    logic [3:0]    lane_mask;
    logic [3:0]    wr_lanes;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   ld_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs; reset masks accept and commit so it wins
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    commit     = !rst;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, wait counter and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cap_we    <= 1'b0;
            cap_f3    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            if (accept) begin
                cap_we    <= bus.req_we;
                cap_f3    <= bus.req_func3;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
                cnt       <= CW'(WAIT_CYCLES);
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == ACCESS && cnt == '0) begin
                rdata_q <= (acc_err || cap_we) ? '0 : ld_data;
                err_q   <= acc_err;
            end
        end
    end

    // Error decision, store lane steering and load extension from the captured request
    always_comb begin
        off     = cap_addr[1:0];
        size    = access_size(cap_f3);
        acc_err = !access_legal(cap_we, cap_f3, off) || (cap_addr >= 32'(DEPTH_BYTES));

        case (size)
            3'd1:    lane_mask = 4'b0001 << off;
            3'd2:    lane_mask = 4'b0011 << off;
            3'd4:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        wr_lanes = (commit && cap_we && !acc_err) ? lane_mask : 4'b0000;

        case (size)
            3'd1:    wr_data = {4{cap_wdata[7:0]}};
            3'd2:    wr_data = {2{cap_wdata[15:0]}};
            default: wr_data = cap_wdata;
        endcase

        rd_shift = rd_word >> {off, 3'b000};
        case (cap_f3)
            F3_B:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_BU:   ld_data = {24'h0, rd_shift[7:0]};
            F3_H:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_HU:   ld_data = {16'h0, rd_shift[15:0]};
            F3_W:    ld_data = rd_word;
            default: ld_data = '0;
        endcase
    end

    dmem_byte_array #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_array (
        .clk   (clk),
        .we    (wr_lanes),
        .idx   (cap_addr[AW+1:2]),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed scoreboard bench for dmem_lsu with one and zero wait states.
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_lsu_if a_if ();
    dmem_lsu_if b_if ();

    dmem_lsu #(.DEPTH_BYTES(1024), .WAIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    dmem_lsu #(.DEPTH_BYTES(1024), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic g_req_ready(input bit sel);
        return sel ? b_if.req_ready : a_if.req_ready;
    endfunction
    function automatic logic g_rsp_valid(input bit sel);
        return sel ? b_if.rsp_valid : a_if.rsp_valid;
    endfunction
    function automatic logic [31:0] g_rsp_rdata(input bit sel);
        return sel ? b_if.rsp_rdata : a_if.rsp_rdata;
    endfunction
    function automatic logic g_rsp_err(input bit sel);
        return sel ? b_if.rsp_err : a_if.rsp_err;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            b_if.req_valid = v; b_if.req_we = we; b_if.req_func3 = f3;
            b_if.req_addr = addr; b_if.req_wdata = wdata;
        end else begin
            a_if.req_valid = v; a_if.req_we = we; a_if.req_func3 = f3;
            a_if.req_addr = addr; a_if.req_wdata = wdata;
        end
    endtask

    task automatic set_rsp_ready(input bit sel, input logic r);
        if (sel) b_if.rsp_ready = r;
        else     a_if.rsp_ready = r;
    endtask

    // One full request/response; expected result is queued at accept time
    task automatic txn(input bit sel, input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int stall);
        int   n;
        int   lat;
        exp_t e;
        @(negedge clk);
        drive(sel, 1'b1, we, f3, addr, wdata);
        n = 0;
        while (!g_req_ready(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept"}, 32'(g_req_ready(sel)), 32'd1);
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        lat = 0;
        while (!g_rsp_valid(sel) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), sel ? 32'd1 : 32'd2);
        for (int i = 0; i < stall; i++) begin
            chk({tag, " stall valid"}, 32'(g_rsp_valid(sel)), 32'd1);
            chk({tag, " stall rdata"}, g_rsp_rdata(sel), sb_q[0].rdata);
            chk({tag, " stall req_ready"}, 32'(g_req_ready(sel)), 32'd0);
            @(negedge clk);
        end
        if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " rdata"}, g_rsp_rdata(sel), e.rdata);
            chk({tag, " err"}, 32'(g_rsp_err(sel)), 32'(e.err));
        end
        set_rsp_ready(sel, 1'b1);
        @(negedge clk);
        set_rsp_ready(sel, 1'b0);
        chk({tag, " idle valid"}, 32'(g_rsp_valid(sel)), 32'd0);
        chk({tag, " idle ready"}, 32'(g_req_ready(sel)), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_rsp_ready(1'b0, 1'b0);
        set_rsp_ready(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(a_if.req_ready), 32'd0);
        chk("reset rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        chk("reset rsp_rdata", a_if.rsp_rdata, 32'h0);
        chk("reset rsp_err",   32'(a_if.rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(a_if.req_ready), 32'd1);

        // word store/load round trip
        txn(1'b0, "sw10",  1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        txn(1'b0, "lw10",  1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // byte store into a known word, then extended loads
        txn(1'b0, "sw20",  1'b1, F3_W,  32'h20, 32'h11223344, 32'h0, 1'b0, 0);
        txn(1'b0, "sb21",  1'b1, F3_B,  32'h21, 32'hABCDEF80, 32'h0, 1'b0, 0);
        txn(1'b0, "lb21",  1'b0, F3_B,  32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        txn(1'b0, "lbu21", 1'b0, F3_BU, 32'h21, 32'h0, 32'h00000080, 1'b0, 0);
        txn(1'b0, "lw20",  1'b0, F3_W,  32'h20, 32'h0, 32'h11228044, 1'b0, 0);
        txn(1'b0, "lh20",  1'b0, F3_H,  32'h20, 32'h0, 32'hFFFF8044, 1'b0, 0);
        txn(1'b0, "lhu20", 1'b0, F3_HU, 32'h20, 32'h0, 32'h00008044, 1'b0, 0);
        txn(1'b0, "lh22",  1'b0, F3_H,  32'h22, 32'h0, 32'h00001122, 1'b0, 0);
        txn(1'b0, "sh22",  1'b1, F3_H,  32'h22, 32'h0000A5C3, 32'h0, 1'b0, 0);
        txn(1'b0, "lw20b", 1'b0, F3_W,  32'h20, 32'h0, 32'hA5C38044, 1'b0, 0);

        // rejected accesses leave memory untouched
        txn(1'b0, "sh13",   1'b1, F3_H,   32'h13,  32'h0000AAAA, 32'h0, 1'b1, 0);
        txn(1'b0, "lw10b",  1'b0, F3_W,   32'h10,  32'h0, 32'hDEADBEEF, 1'b0, 0);
        txn(1'b0, "lw400",  1'b0, F3_W,   32'h400, 32'h0, 32'h0, 1'b1, 0);
        txn(1'b0, "lw12",   1'b0, F3_W,   32'h12,  32'h0, 32'h0, 1'b1, 0);
        txn(1'b0, "ld011",  1'b0, 3'b011, 32'h20,  32'h0, 32'h0, 1'b1, 0);
        txn(1'b0, "sw24",   1'b1, F3_W,   32'h24,  32'h55667788, 32'h0, 1'b0, 0);
        txn(1'b0, "st100",  1'b1, 3'b100, 32'h24,  32'hFFFFFFFF, 32'h0, 1'b1, 0);
        txn(1'b0, "lw24",   1'b0, F3_W,   32'h24,  32'h0, 32'h55667788, 1'b0, 0);
        txn(1'b0, "sw3fc",  1'b1, F3_W,   32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        txn(1'b0, "lw3fc",  1'b0, F3_W,   32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        // consumer stall holds the response
        txn(1'b0, "stall", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

        // zero wait states
        txn(1'b1, "b_sw40", 1'b1, F3_W, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, 0);
        txn(1'b1, "b_lw40", 1'b0, F3_W, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 0);
        txn(1'b1, "b_lb43", 1'b0, F3_B, 32'h43, 32'h0, 32'h0000000B, 1'b0, 0);

        // reset during ACCESS drops the store and its response
        txn(1'b0, "sw30z", 1'b1, F3_W, 32'h30, 32'h0, 32'h0, 1'b0, 0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, F3_W, 32'h30, 32'h12345678);
        chk("abort accept", 32'(a_if.req_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("abort in access", 32'(a_if.rsp_valid), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort rsp_valid", 32'(a_if.rsp_valid), 32'd0);
            chk("abort req_ready", 32'(a_if.req_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort no rsp", 32'(a_if.rsp_valid), 32'd0);
        txn(1'b0, "lw30", 1'b0, F3_W, 32'h30, 32'h0, 32'h0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
